// File: rtl/fp_muldiv_pipe_if.sv
// rtl/fp_muldiv_pipe_if.sv - operand issue / result writeback bundle for fp_muldiv_pipe
//
// Signals:
//   in_valid/in_ready   operand handshake (issuer -> unit)
//   sel                 0 = multiply a*b, 1 = divide a/b
//   a, b                operands {sign, exp, frac}, W bits
//   out_valid/out_ready result handshake (unit -> consumer)
//   R                   result, W bits
//   io/dz/of/uf/i_flag  invalid, divide-by-zero, overflow, underflow, inexact
// Modports: master = issuer/consumer side, slave = the arithmetic unit.
interface fp_muldiv_pipe_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] R;
    logic         io_flag;
    logic         dz_flag;
    logic         of_flag;
    logic         uf_flag;
    logic         i_flag;

    modport master (
        output in_valid, sel, a, b, out_ready,
        input  in_ready, out_valid, R, io_flag, dz_flag, of_flag, uf_flag, i_flag
    );

    modport slave (
        input  in_valid, sel, a, b, out_ready,
        output in_ready, out_valid, R, io_flag, dz_flag, of_flag, uf_flag, i_flag
    );
endinterface

// File: rtl/fp_muldiv_pipe.sv
// rtl/fp_muldiv_pipe.sv - parametrised floating-point multiply / iterative divide unit
//
// Ports:
//   clk   rising-edge clock
//   arst  synchronous active-high reset (wins over en)
//   en    clock enable; 0 freezes all state and outputs
//   bus   fp_muldiv_pipe_if slave: operand handshake, result handshake, exception flags
// One operation in flight. Specials finish in 1 cycle, MUL in 3, DIV in MW+5.
// Subnormal inputs are flushed to signed zero; results that underflow become signed zero.
module fp_muldiv_pipe #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            en,
    fp_muldiv_pipe_if.slave bus
);
    localparam int W  = 1 + EW + MW;
    localparam int XW = EW + 2;
    localparam int CW = $clog2(MW + 4);
    localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EW - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX  = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] E_ONE = XW'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 op_div;
    logic                 sgn;
    logic signed [XW-1:0] e_r;
    logic [MW:0]          ma, mb;
    logic [2*MW+1:0]      prod;
    logic [MW+2:0]        q;
    logic [MW+1:0]        rem;
    logic [W-1:0]         r_r;
    logic [4:0]           fl_r;     // {io, dz, of, uf, i}
    logic                 in_ready_r, out_valid_r;

    // ---------------- operand classing ----------------
    logic          sa, sb, s_in;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

    assign {sa, ea, fa} = bus.a;
    assign {sb, eb, fb} = bus.b;
    assign s_in   = sa ^ sb;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign a_snan = a_nan && !fa[MW-1];
    assign b_snan = b_nan && !fb[MW-1];

    // ---------------- special-operand result ----------------
    logic         sp_hit, sp_io, sp_dz;
    logic [W-1:0] sp_r;

    always_comb begin
        sp_hit = 1'b1;
        sp_io  = 1'b0;
        sp_dz  = 1'b0;
        sp_r   = '0;
        if (a_nan || b_nan) begin
            sp_r  = QNAN;
            sp_io = a_snan || b_snan;
        end else if ((!bus.sel && ((a_zero && b_inf) || (a_inf && b_zero))) ||
                     (bus.sel && ((a_inf && b_inf) || (a_zero && b_zero)))) begin
            sp_r  = QNAN;
            sp_io = 1'b1;
        end else if (a_inf || (!bus.sel && b_inf)) begin
            sp_r = {s_in, {EW{1'b1}}, {MW{1'b0}}};
        end else if (bus.sel && b_zero) begin
            // a is finite and nonzero here
            sp_r  = {s_in, {EW{1'b1}}, {MW{1'b0}}};
            sp_dz = 1'b1;
        end else if ((bus.sel && b_inf) || a_zero || b_zero) begin
            sp_r = {s_in, {(W-1){1'b0}}};
        end else begin
            sp_hit = 1'b0;
        end
    end

    logic signed [XW-1:0] xa, xb, e_in;
    assign xa   = {2'b00, ea};
    assign xb   = {2'b00, eb};
    assign e_in = bus.sel ? (xa - xb + BIAS) : (xa + xb - BIAS);

    // ---------------- restoring divide step ----------------
    logic          rem_ge;
    logic [MW+1:0] rem_sub;
    assign rem_ge  = (rem >= {1'b0, mb});
    assign rem_sub = rem_ge ? (rem - {1'b0, mb}) : rem;

    // ---------------- normalise and round ----------------
    logic [MW-1:0]        nm_frac, rnd_frac;
    logic                 g, rr, st, inc;
    logic [MW+1:0]        sum;
    logic signed [XW-1:0] e_n;

    always_comb begin
        nm_frac = '0;
        g       = 1'b0;
        rr      = 1'b0;
        st      = 1'b0;
        e_n     = e_r;
        if (op_div) begin
            if (q[MW+2]) begin
                nm_frac = q[MW+1:2];
                g       = q[1];
                rr      = q[0];
            end else begin
                // the true round bit is gone; the remainder sticky keeps R|S exact
                nm_frac = q[MW:1];
                g       = q[0];
                e_n     = e_r - E_ONE;
            end
            st = (rem != '0);
        end else begin
            if (prod[2*MW+1]) begin
                nm_frac = prod[2*MW:MW+1];
                g       = prod[MW];
                rr      = prod[MW-1];
                st      = |prod[MW-2:0];
                e_n     = e_r + E_ONE;
            end else begin
                nm_frac = prod[2*MW-1:MW];
                g       = prod[MW-1];
                rr      = prod[MW-2];
                st      = |prod[MW-3:0];
            end
        end
        inc      = g & (rr | st | nm_frac[0]);
        sum      = {2'b01, nm_frac} + {{(MW+1){1'b0}}, inc};
        rnd_frac = sum[MW-1:0];
        if (sum[MW+1]) begin
            rnd_frac = sum[MW:1];
            e_n      = e_n + E_ONE;
        end
    end

    // ---------------- control and state ----------------
    always_ff @(posedge clk) begin
        if (arst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_div      <= 1'b0;
            sgn         <= 1'b0;
            e_r         <= '0;
            ma          <= '0;
            mb          <= '0;
            prod        <= '0;
            q           <= '0;
            rem         <= '0;
            r_r         <= '0;
            fl_r        <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        op_div     <= bus.sel;
                        sgn        <= s_in;
                        e_r        <= e_in;
                        ma         <= {1'b1, fa};
                        mb         <= {1'b1, fb};
                        rem        <= {2'b01, fa};
                        q          <= '0;
                        in_ready_r <= 1'b0;
                        if (sp_hit) begin
                            r_r         <= sp_r;
                            fl_r        <= {sp_io, sp_dz, 3'b000};
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt   <= bus.sel ? CW'(MW + 3) : CW'(1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_div) begin
                        q   <= {q[MW+1:0], rem_ge};
                        rem <= {rem_sub[MW:0], 1'b0};
                    end else begin
                        prod <= {{(MW+1){1'b0}}, ma} * {{(MW+1){1'b0}}, mb};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= NORM;
                end
                NORM: begin
                    if (e_n >= EMAX) begin
                        r_r  <= {sgn, {EW{1'b1}}, {MW{1'b0}}};
                        fl_r <= 5'b00101;
                    end else if (e_n < E_ONE) begin
                        r_r  <= {sgn, {(W-1){1'b0}}};
                        fl_r <= 5'b00011;
                    end else begin
                        r_r  <= {sgn, e_n[EW-1:0], rnd_frac};
                        fl_r <= {4'b0000, g | rr | st};
                    end
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.R         = r_r;
    assign {bus.io_flag, bus.dz_flag, bus.of_flag, bus.uf_flag, bus.i_flag} = fl_r;
endmodule

// File: tb/tb_fp_muldiv_pipe.sv
// tb/tb_fp_muldiv_pipe.sv - directed self-checking bench for fp_muldiv_pipe (single and half precision)
module tb_fp_muldiv_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    fp_muldiv_pipe_if #(.W(32)) b32 ();
    fp_muldiv_pipe_if #(.W(16)) b16 ();

    fp_muldiv_pipe #(.EW(8), .MW(23)) dut32 (.clk(clk), .arst(rst), .en(en), .bus(b32.slave));
    fp_muldiv_pipe #(.EW(5), .MW(10)) dut16 (.clk(clk), .arst(rst), .en(en), .bus(b16.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Issue one op and wait for its result; lat = -1 when the result never shows.
    task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output logic [31:0] r, output logic [4:0] fl);
        @(negedge clk);
        if (half) begin
            b16.a = a[15:0]; b16.b = b[15:0]; b16.sel = s; b16.in_valid = 1'b1;
        end else begin
            b32.a = a; b32.b = b; b32.sel = s; b32.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        b32.in_valid = 1'b0;
        lat = 1;
        while (!(half ? b16.out_valid : b32.out_valid) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!(half ? b16.out_valid : b32.out_valid)) lat = -1;
        if (half) begin
            r  = {16'h0000, b16.R};
            fl = {b16.io_flag, b16.dz_flag, b16.of_flag, b16.uf_flag, b16.i_flag};
        end else begin
            r  = b32.R;
            fl = {b32.io_flag, b32.dz_flag, b32.of_flag, b32.uf_flag, b32.i_flag};
        end
    endtask

    task automatic take();
        @(negedge clk);
        b32.out_ready = 1'b1;
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        b16.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", b32.in_ready); end
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", b32.out_valid); end
        n_cmp++; if (b32.R !== 32'h0) begin n_bad++; $display("FAIL reset_R: got %h expected 00000000", b32.R); end
        n_cmp++; if ({b32.io_flag, b32.dz_flag, b32.of_flag, b32.uf_flag, b32.i_flag} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 00000",
                              {b32.io_flag, b32.dz_flag, b32.of_flag, b32.uf_flag, b32.i_flag});
        end
        n_cmp++; if (b16.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset16_in_ready: got %b expected 1", b16.in_ready); end
    endtask

    // Directed vectors: {half, a, b, sel, expected R, expected flags, expected latency}
    typedef struct {
        string       name;
        bit          half;
        logic [31:0] a, b;
        logic        s;
        logic [31:0] r;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    task automatic test_vectors();
        vec_t v[$];
        int lat;
        logic [31:0] r;
        logic [4:0] fl;
        v.push_back('{"mul_1p5x2",  0, 32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000, 3});
        v.push_back('{"div_1by3",   0, 32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB, 5'b00001, 28});
        v.push_back('{"div_by_0",   0, 32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000, 5'b01000, 1});
        v.push_back('{"mul_0xinf",  0, 32'h00000000, 32'h7F800000, 1'b0, 32'h7FC00000, 5'b10000, 1});
        v.push_back('{"mul_ovf",    0, 32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 5'b00101, 3});
        v.push_back('{"mul_unf",    0, 32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 5'b00011, 3});
        v.push_back('{"mul_snan",   0, 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000, 1});
        v.push_back('{"mul_qnan",   0, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00000, 1});
        v.push_back('{"div_x_inf",  0, 32'hC0000000, 32'h7F800000, 1'b1, 32'h80000000, 5'b00000, 1});
        v.push_back('{"div_inf_0",  0, 32'h7F800000, 32'h00000000, 1'b1, 32'h7F800000, 5'b00000, 1});
        v.push_back('{"mul_tie_up", 0, 32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 5'b00001, 3});
        v.push_back('{"mul_tie_ev", 0, 32'h3F800003, 32'h3FC00000, 1'b0, 32'h3FC00004, 5'b00001, 3});
        v.push_back('{"div_neg",    0, 32'hC0C00000, 32'h40000000, 1'b1, 32'hC0400000, 5'b00000, 28});
        v.push_back('{"h_mul",      1, 32'h00003C00, 32'h00004000, 1'b0, 32'h00004000, 5'b00000, 3});
        v.push_back('{"h_div",      1, 32'h00004200, 32'h00004000, 1'b1, 32'h00003E00, 5'b00000, 15});
        foreach (v[i]) begin
            run_op(v[i].half, v[i].a, v[i].b, v[i].s, lat, r, fl);
            n_cmp++; if (r !== v[i].r) begin n_bad++; $display("FAIL %s_R: got %h expected %h", v[i].name, r, v[i].r); end
            n_cmp++; if (fl !== v[i].fl) begin n_bad++; $display("FAIL %s_flags: got %b expected %b", v[i].name, fl, v[i].fl); end
            n_cmp++; if (lat != v[i].lat) begin n_bad++; $display("FAIL %s_latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
            take();
        end
    endtask

    task automatic test_hold();
        int lat;
        logic [31:0] r;
        logic [4:0] fl;
        run_op(0, 32'h7F000000, 32'h40000000, 1'b0, lat, r, fl);
        @(negedge clk);
        b32.a = 32'h0; b32.b = 32'h0; b32.sel = 1'b0; b32.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (b32.R !== 32'h7F800000 || b32.out_valid !== 1'b1) begin
                n_bad++; $display("FAIL hold_R_%0d: got %h/%b expected 7f800000/1", k, b32.R, b32.out_valid);
            end
            n_cmp++; if ({b32.of_flag, b32.i_flag} !== 2'b11) begin
                n_bad++; $display("FAIL hold_flags_%0d: got %b expected 11", k, {b32.of_flag, b32.i_flag});
            end
            n_cmp++; if (b32.in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready_%0d: got %b expected 0", k, b32.in_ready); end
        end
        b32.in_valid = 1'b0;
        take();
        @(posedge clk); #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL busy_ignored: got out_valid %b expected 0", b32.out_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] r;
        logic [4:0] fl;
        run_op(0, 32'h3FC00000, 32'h40000000, 1'b0, lat, r, fl);
        @(negedge clk);
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle: got in_ready %b out_valid %b expected 1 0", b32.in_ready, b32.out_valid);
        end
        run_op(0, 32'h40000000, 32'h40000000, 1'b0, lat, r, fl);
        n_cmp++; if (r !== 32'h40800000 || lat != 3) begin
            n_bad++; $display("FAIL b2b_second: got %h lat %0d expected 40800000 lat 3", r, lat);
        end
        b32.out_ready = 1'b0;
        take();
    endtask

    task automatic test_en_stall();
        int lat;
        @(negedge clk);
        b32.a = 32'h3F800000; b32.b = 32'h40400000; b32.sel = 1'b1; b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        lat = 1;
        repeat (4) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        en = 1'b0;
        repeat (10) begin @(posedge clk); lat++; end
        @(negedge clk);
        n_cmp++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL en_frozen: got out_valid %b in_ready %b expected 0 0", b32.out_valid, b32.in_ready);
        end
        en = 1'b1;
        while (!b32.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != 38) begin n_bad++; $display("FAIL en_latency: got %0d expected 38", lat); end
        n_cmp++; if (b32.R !== 32'h3EAAAAAB || b32.i_flag !== 1'b1) begin
            n_bad++; $display("FAIL en_result: got %h i=%b expected 3eaaaaab i=1", b32.R, b32.i_flag);
        end
        take();
    endtask

    task automatic test_reset_mid_div();
        int lat;
        logic [31:0] r;
        logic [4:0] fl;
        @(negedge clk);
        b32.a = 32'h3F800000; b32.b = 32'h40400000; b32.sel = 1'b1; b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_div: got in_ready %b out_valid %b expected 1 0", b32.in_ready, b32.out_valid);
        end
        run_op(0, 32'h3FC00000, 32'h40000000, 1'b0, lat, r, fl);
        n_cmp++; if (r !== 32'h40400000 || lat != 3) begin
            n_bad++; $display("FAIL rst_recover: got %h lat %0d expected 40400000 lat 3", r, lat);
        end
        take();
    endtask

    initial begin
        b32.in_valid = 1'b0; b32.sel = 1'b0; b32.a = '0; b32.b = '0; b32.out_ready = 1'b0;
        b16.in_valid = 1'b0; b16.sel = 1'b0; b16.a = '0; b16.b = '0; b16.out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_hold();
        test_back_to_back();
        test_en_stall();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
